// File: rtl/rv32i_pkg.sv
// Shared types for the RV32I memory arbiter: FSM state encoding and port indices.
package rv32i_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rv32i_arb_pick.sv
// Combinational winner select: port 0 wins unless only port 1 requests or force1 is set.
module rv32i_arb_pick
    import rv32i_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic force1,
    output logic valid,
    output logic idx
);

    always_comb begin
        valid = req0 | req1;
        idx   = (req1 && (!req0 || force1)) ? PORT1 : PORT0;
    end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Two-port arbiter in front of a single-ported RAM: one access every two cycles.
// Optional starvation guard for port 1 enabled by defining MEM_ARB_STARVE_GUARD_EN.
module rv32i_mem_arbiter
    import rv32i_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        we0,
    input  logic [3:0]  be0,
    input  logic [29:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [3:0]  be1,
    input  logic [29:0] addr1,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        rvalid0,
    output logic [31:0] rdata0,
    output logic        gnt1,
    output logic        rvalid1,
    output logic [31:0] rdata1,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    arb_state_t state;
    logic       owner;
    logic       pick_valid;
    logic       pick_idx;
    logic       force1;
    logic       arbitrating;

    assign arbitrating = (state != ACCESS);

    rv32i_arb_pick u_pick (
        .req0   (req0),
        .req1   (req1),
        .force1 (force1),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 2);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;

    assign force1 = (starve_cnt == LIMIT);

    // Counts port-0 wins while port 1 keeps waiting; never passes LIMIT because
    // reaching it forces the next contested grant to port 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!req1) begin
            starve_cnt <= '0;
        end else if (arbitrating && pick_valid) begin
            if (pick_idx == PORT1) begin
                starve_cnt <= '0;
            end else begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`else
    assign force1 = 1'b0;
`endif

    // Arbitrate in IDLE and RESP; ACCESS always lasts one cycle and is followed by RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= PORT0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            mem_en  <= 1'b0;
            case (state)
                ACCESS: begin
                    state   <= RESP;
                    rvalid0 <= (owner == PORT0);
                    rvalid1 <= (owner == PORT1);
                end
                default: begin
                    if (pick_valid) begin
                        state  <= ACCESS;
                        owner  <= pick_idx;
                        mem_en <= 1'b1;
                        gnt0   <= (pick_idx == PORT0);
                        gnt1   <= (pick_idx == PORT1);
                        if (pick_idx == PORT1) begin
                            mem_we    <= we1;
                            mem_be    <= be1;
                            mem_addr  <= addr1;
                            mem_wdata <= wdata1;
                        end else begin
                            mem_we    <= we0;
                            mem_be    <= be0;
                            mem_addr  <= addr0;
                            mem_wdata <= wdata0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // The RAM returns data during RESP; mem_we still describes the owner's command then.
    always_comb begin
        rdata0 = (rvalid0 && !mem_we) ? mem_rdata : 32'd0;
        rdata1 = (rvalid1 && !mem_we) ? mem_rdata : 32'd0;
    end

endmodule
